uart_rx_param: RTL and testbench

Parametrised, fully synchronous UART receiver: the next-generation RX block for the UART/LED test path. It supports run-time selectable 5–9 data bits, none/even/odd parity and 1 or 2 stop bits. It uses 3-sample majority voting at mid-bit and reports parity, framing and break errors. It sits between the baud tick generator (Tick) and the byte consumer (LED/command logic). All state is clocked by Clk, and Tick is used only as a clock enable.

---
 rtl/uart_rx_param_if.sv | 25 ++
 rtl/uart_rx_param.sv | 111 +++++++++++
 tb/tb_uart_rx_param.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line, frame configuration and received-word outputs of uart_rx_param.
interface uart_rx_param_if #(
   parameter int MAX_BITS = 9
);
   logic                Tick;
   logic                RxEn;
   logic                Rx;
   logic [3:0]          NBits;
   logic [1:0]          ParityMode;
   logic                StopBits;
   logic [MAX_BITS-1:0] RxData;
   logic                RxValid;
   logic                ParityErr;
   logic                FrameErr;
   logic                Break;
   logic                Busy;
   modport master (
      output Tick, RxEn, Rx, NBits, ParityMode, StopBits,
      input  RxData, RxValid, ParityErr, FrameErr, Break, Busy
   );
   modport slave (
      input  Tick, RxEn, Rx, NBits, ParityMode, StopBits,
      output RxData, RxValid, ParityErr, FrameErr, Break, Busy
   );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver, 5..MAX_BITS data bits, optional parity, 1/2 stop bits,
// 3-sample mid-bit majority vote, parity/framing/break reporting. Tick is a clock enable only.
module uart_rx_param #(
   parameter int OVERSAMPLE = 16,
   parameter int MAX_BITS   = 9
) (
   input logic            Clk,
   input logic            Rst_n,
   uart_rx_param_if.slave bus
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 + 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t              state, state_n;
   logic                rx_m, rxs;
   logic [1:0]          samp;
   logic [CW-1:0]       cnt;
   logic [3:0]          bidx, nb, nb_in;
   logic [1:0]          pm;
   logic                sb, par_en, par_bit, ferr, ferr_fin;
   logic                maj, mid, last, go, fin;
   logic [MAX_BITS-1:0] data;

   assign nb_in = bus.NBits < 4'd5 ? 4'd5 : int'(bus.NBits) > MAX_BITS ? 4'(MAX_BITS) : bus.NBits;
   // samp holds the two previous tick samples; with the current rxs they form the vote window
   assign maj      = (samp[1] & samp[0]) | (samp[1] & rxs) | (samp[0] & rxs);
   assign mid      = bus.Tick && cnt == MID;
   assign last     = bus.Tick && cnt == LAST;
   assign par_en   = pm == 2'b01 || pm == 2'b10;
   assign ferr_fin = ferr | ~maj;
   assign bus.Busy = state != IDLE;

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      go      = 1'b0;
      fin     = 1'b0;
      if (!bus.RxEn) state_n = IDLE;
      else case (state)
         IDLE:      if (bus.Tick && !rxs) begin state_n = START; go = 1'b1; end
         START:     state_n = mid && maj ? IDLE : last ? DATA : START;
         DATA:      state_n = last && bidx == nb - 4'd1 ? (par_en ? PARITY : STOP) : DATA;
         PARITY:    state_n = last ? STOP : PARITY;
         STOP:      if (mid && bidx == {3'b000, sb}) begin fin = 1'b1; state_n = maj ? IDLE : WAIT_HIGH; end
         WAIT_HIGH: state_n = bus.Tick && rxs ? IDLE : WAIT_HIGH;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         rx_m <= 1'b1;
         rxs  <= 1'b1;
         samp <= 2'b11;
         cnt  <= '0;
         bidx <= '0;
      end else begin
         rx_m <= bus.Rx;
         rxs  <= rx_m;
         if (bus.Tick) samp <= {samp[0], rxs};
         cnt <= state == IDLE || state_n == IDLE || state_n == WAIT_HIGH ? '0 :
                bus.Tick ? (cnt == LAST ? '0 : cnt + CW'(1)) : cnt;
         if (go || (state == DATA && state_n != DATA)) bidx <= '0;
         else if (last && (state == DATA || state == STOP)) bidx <= bidx + 4'd1;
      end

   // frame accumulators; the configuration is frozen for the whole frame at start detection
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         nb      <= '0;
         pm      <= '0;
         sb      <= 1'b0;
         data    <= '0;
         par_bit <= 1'b0;
         ferr    <= 1'b0;
      end else if (go) begin
         nb      <= nb_in;
         pm      <= bus.ParityMode;
         sb      <= bus.StopBits;
         data    <= '0;
         par_bit <= 1'b0;
         ferr    <= 1'b0;
      end else begin
         if (mid && state == DATA) data <= data | (MAX_BITS'(maj) << bidx);
         if (mid && state == PARITY) par_bit <= maj;
         if (mid && state == STOP && !maj) ferr <= 1'b1;
      end

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         bus.RxData    <= '0;
         bus.RxValid   <= 1'b0;
         bus.ParityErr <= 1'b0;
         bus.FrameErr  <= 1'b0;
         bus.Break     <= 1'b0;
      end else begin
         bus.RxValid <= fin;
         if (fin) begin
            bus.RxData    <= data;
            bus.ParityErr <= par_en && ((^data ^ par_bit) != (pm == 2'b10));
            bus.FrameErr  <= ferr_fin;
            bus.Break     <= data == '0 && !par_bit && ferr_fin;
         end
      end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomized frames checked against a frame-level model of the receiver.
module tb_uart_rx_param;
   localparam int OS = 16;
   localparam int MB = 9;

   logic        Clk   = 1'b0;
   logic        Rst_n = 1'b0;
   int          cmp   = 0;
   int          errs  = 0;
   logic [11:0] got[$];
   logic [11:0] rec, exp;

   uart_rx_param_if #(.MAX_BITS(MB)) bus ();
   uart_rx_param #(.OVERSAMPLE(OS), .MAX_BITS(MB)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

   always #5 Clk = ~Clk;

   initial begin
      bus.Tick = 1'b0;
      forever begin
         repeat (3) @(negedge Clk);
         bus.Tick = 1'b1;
         @(negedge Clk);
         bus.Tick = 1'b0;
      end
   end

   always @(negedge Clk)
      if (bus.RxValid) got.push_back({bus.RxData, bus.ParityErr, bus.FrameErr, bus.Break});

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge Clk);
         while (!bus.Tick) @(posedge Clk);
      end
      #1;
   endtask

   // expected {RxData, ParityErr, FrameErr, Break} of one frame as it was put on the line
   function automatic logic [11:0] model(input logic [8:0] d, input logic [3:0] nraw, input logic [1:0] pm,
                                         input logic pbit, input logic sb, input logic [1:0] stopv);
      int n;
      logic [8:0] v;
      logic pen, perr, ferr, brk;
      n    = nraw < 5 ? 5 : nraw > 9 ? 9 : int'(nraw);
      v    = d & 9'((1 << n) - 1);
      pen  = pm == 2'b01 || pm == 2'b10;
      perr = pen && ((($countones(v) + int'(pbit)) % 2) != (pm == 2'b10 ? 1 : 0));
      ferr = !stopv[0] || (sb && !stopv[1]);
      brk  = v == 0 && !(pen && pbit) && ferr;
      return {v, perr, ferr, brk};
   endfunction

   // drives at most cut bit periods of the frame, start bit first
   task automatic send(input logic [8:0] d, input logic [3:0] nraw, input logic [1:0] pm, input logic pbit,
                       input logic sb, input logic [1:0] stopv, input int cut);
      logic bits[$];
      int n;
      n = nraw < 5 ? 5 : nraw > 9 ? 9 : int'(nraw);
      bus.NBits      = nraw;
      bus.ParityMode = pm;
      bus.StopBits   = sb;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) bits.push_back(d[i]);
      if (pm == 2'b01 || pm == 2'b10) bits.push_back(pbit);
      bits.push_back(stopv[0]);
      if (sb) bits.push_back(stopv[1]);
      for (int i = 0; i < bits.size() && i < cut; i++) begin
         bus.Rx = bits[i];
         wait_ticks(OS);
      end
   endtask

   task automatic idle(input int n);
      bus.Rx = 1'b1;
      wait_ticks(n);
   endtask

   task automatic test_reset();
      cmp++;
      if ({bus.RxData, bus.RxValid, bus.ParityErr, bus.FrameErr, bus.Break, bus.Busy} !== '0) begin
         errs++;
         $display("FAIL reset_hold: got %h expected 0", {bus.RxData, bus.RxValid, bus.ParityErr, bus.FrameErr, bus.Break, bus.Busy});
      end
      @(negedge Clk);
      Rst_n = 1'b1;
      idle(4);
      cmp++;
      if ({bus.RxData, bus.RxValid, bus.ParityErr, bus.FrameErr, bus.Break, bus.Busy} !== '0) begin
         errs++;
         $display("FAIL reset_release: got %h expected 0", {bus.RxData, bus.RxValid, bus.ParityErr, bus.FrameErr, bus.Break, bus.Busy});
      end
   endtask

   task automatic test_8n1();
      got.delete();
      send(9'h0A5, 4'd8, 2'b00, 1'b0, 1'b0, 2'b11, 99);
      idle(8);
      exp = model(9'h0A5, 4'd8, 2'b00, 1'b0, 1'b0, 2'b11);
      rec = got.size() > 0 ? got[0] : 12'hxxx;
      cmp++;
      if (got.size() != 1) begin errs++; $display("FAIL 8n1_count: got %0d expected 1", got.size()); end
      cmp++;
      if (rec !== exp) begin errs++; $display("FAIL 8n1_word: got %h expected %h", rec, exp); end
      cmp++;
      if (bus.Busy !== 1'b0) begin errs++; $display("FAIL 8n1_busy: got %b expected 0", bus.Busy); end
   endtask

   task automatic test_7e1();
      for (int p = 1; p >= 0; p--) begin
         got.delete();
         send(9'h041, 4'd7, 2'b01, 1'(p), 1'b0, 2'b11, 99);
         idle(8);
         exp = model(9'h041, 4'd7, 2'b01, 1'(p), 1'b0, 2'b11);
         rec = got.size() > 0 ? got[0] : 12'hxxx;
         cmp++;
         if (got.size() != 1) begin errs++; $display("FAIL 7e1_count p=%0d: got %0d expected 1", p, got.size()); end
         cmp++;
         if (rec !== exp) begin errs++; $display("FAIL 7e1_word p=%0d: got %h expected %h", p, rec, exp); end
      end
   endtask

   task automatic test_9o2();
      logic [1:0] stopv;
      for (int k = 0; k < 2; k++) begin
         stopv = k == 0 ? 2'b11 : 2'b01;
         got.delete();
         send(9'h1FF, 4'd9, 2'b10, 1'b0, 1'b1, stopv, 99);
         idle(8);
         exp = model(9'h1FF, 4'd9, 2'b10, 1'b0, 1'b1, stopv);
         rec = got.size() > 0 ? got[0] : 12'hxxx;
         cmp++;
         if (got.size() != 1) begin errs++; $display("FAIL 9o2_count stop=%b: got %0d expected 1", stopv, got.size()); end
         cmp++;
         if (rec !== exp) begin errs++; $display("FAIL 9o2_word stop=%b: got %h expected %h", stopv, rec, exp); end
      end
   endtask

   task automatic test_false_start();
      got.delete();
      bus.Rx = 1'b0;
      wait_ticks(4);
      cmp++;
      if (bus.Busy !== 1'b1) begin errs++; $display("FAIL false_start_detect: busy %b expected 1", bus.Busy); end
      idle(40);
      cmp++;
      if (got.size() != 0) begin errs++; $display("FAIL false_start_count: got %0d expected 0", got.size()); end
      cmp++;
      if (bus.Busy !== 1'b0) begin errs++; $display("FAIL false_start_busy: got %b expected 0", bus.Busy); end
   endtask

   task automatic test_break();
      got.delete();
      bus.NBits = 4'd8; bus.ParityMode = 2'b00; bus.StopBits = 1'b0;
      bus.Rx = 1'b0;
      wait_ticks(20 * OS);
      exp = model(9'h000, 4'd8, 2'b00, 1'b0, 1'b0, 2'b00);
      rec = got.size() > 0 ? got[0] : 12'hxxx;
      cmp++;
      if (got.size() != 1) begin errs++; $display("FAIL break_count: got %0d expected 1", got.size()); end
      cmp++;
      if (rec !== exp) begin errs++; $display("FAIL break_word: got %h expected %h", rec, exp); end
      cmp++;
      if (bus.Busy !== 1'b1) begin errs++; $display("FAIL break_wait_busy: got %b expected 1", bus.Busy); end
      idle(40);
      cmp++;
      if (got.size() != 1) begin errs++; $display("FAIL break_release_count: got %0d expected 1", got.size()); end
      cmp++;
      if (bus.Busy !== 1'b0) begin errs++; $display("FAIL break_release_busy: got %b expected 0", bus.Busy); end
   endtask

   task automatic test_abort();
      got.delete();
      send(9'h03C, 4'd8, 2'b00, 1'b0, 1'b0, 2'b11, 5);
      bus.RxEn = 1'b0;
      bus.Rx   = 1'b1;
      wait_ticks(4);
      cmp++;
      if (bus.Busy !== 1'b0) begin errs++; $display("FAIL abort_en_busy: got %b expected 0", bus.Busy); end
      bus.RxEn = 1'b1;
      idle(30);
      cmp++;
      if (got.size() != 0) begin errs++; $display("FAIL abort_en_count: got %0d expected 0", got.size()); end
      send(9'h03C, 4'd8, 2'b00, 1'b0, 1'b0, 2'b11, 99);
      idle(8);
      rec = got.size() > 0 ? got[0] : 12'hxxx;
      exp = model(9'h03C, 4'd8, 2'b00, 1'b0, 1'b0, 2'b11);
      cmp++;
      if (rec !== exp) begin errs++; $display("FAIL abort_en_next: got %h expected %h", rec, exp); end
      got.delete();
      send(9'h0C3, 4'd8, 2'b01, 1'b0, 1'b0, 2'b11, 6);
      Rst_n = 1'b0;
      #20;
      cmp++;
      if ({bus.RxData, bus.RxValid, bus.ParityErr, bus.FrameErr, bus.Break, bus.Busy} !== '0) begin
         errs++;
         $display("FAIL abort_rst_outputs: got %h expected 0", {bus.RxData, bus.RxValid, bus.ParityErr, bus.FrameErr, bus.Break, bus.Busy});
      end
      @(negedge Clk);
      Rst_n = 1'b1;
      idle(30);
      cmp++;
      if (got.size() != 0) begin errs++; $display("FAIL abort_rst_count: got %0d expected 0", got.size()); end
      send(9'h03C, 4'd8, 2'b00, 1'b0, 1'b0, 2'b11, 99);
      idle(8);
      rec = got.size() > 0 ? got[0] : 12'hxxx;
      cmp++;
      if (got.size() != 1 || rec !== exp) begin
         errs++;
         $display("FAIL abort_rst_next: got %h (count %0d) expected %h (count 1)", rec, got.size(), exp);
      end
   endtask

   task automatic test_random();
      logic [8:0] d;
      logic [3:0] nraw;
      logic [1:0] pm, stopv;
      logic       pbit, sb;
      for (int t = 0; t < 24; t++) begin
         d     = 9'($urandom);
         nraw  = 4'($urandom_range(0, 15));
         pm    = 2'($urandom_range(0, 3));
         pbit  = 1'($urandom);
         sb    = 1'($urandom);
         stopv = $urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b11;
         got.delete();
         send(d, nraw, pm, pbit, sb, stopv, 99);
         idle($urandom_range(4, 24));
         exp = model(d, nraw, pm, pbit, sb, stopv);
         rec = got.size() > 0 ? got[0] : 12'hxxx;
         cmp++;
         if (got.size() != 1) begin errs++; $display("FAIL rand%0d_count: got %0d expected 1", t, got.size()); end
         cmp++;
         if (rec !== exp) begin
            errs++;
            $display("FAIL rand%0d_word d=%h n=%0d pm=%b p=%b sb=%b stop=%b: got %h expected %h", t, d, nraw, pm, pbit, sb, stopv, rec, exp);
         end
      end
   endtask

   initial begin
      bus.RxEn = 1'b1; bus.Rx = 1'b1;
      bus.NBits = 4'd8; bus.ParityMode = 2'b00; bus.StopBits = 1'b0;
      repeat (5) @(negedge Clk);
      test_reset();
      test_8n1();
      test_7e1();
      test_9o2();
      test_false_start();
      test_break();
      test_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
